// File: rtl/readout_feature_quantizer_pkg.sv
// Shared sizing, FSM states and the bin-sum quantizer for the readout feature front end.
// Everything derives from the five base localparams below.
package readout_feature_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DECIM    = 8;
  localparam int NUM_BINS = 16;
  localparam int IN_BW    = 2;
  localparam int SHIFT    = 12;

  localparam int DEC_W = $clog2(DECIM);
  localparam int ACC_W = SAMPLE_W + DEC_W;
  localparam int W     = NUM_BINS * DECIM;
  localparam int OUT_W = 2 * NUM_BINS * IN_BW;
  localparam int CNT_W = $clog2(W);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (IN_BW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(2 ** (IN_BW - 1)));

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  // Arithmetic shift then clamp into the signed IN_BW-bit code range.
  function automatic logic [IN_BW-1:0] quantize(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] q;
    q = sum >>> SHIFT;
    if (q > Q_MAX)      quantize = Q_MAX[IN_BW-1:0];
    else if (q < Q_MIN) quantize = Q_MIN[IN_BW-1:0];
    else                quantize = q[IN_BW-1:0];
  endfunction

endpackage

// File: rtl/readout_feature_quantizer_bin_accum_quant.sv
// Single-channel box-car accumulator; quantizes the bin sum including the sample
// that completes the bin, and restarts the accumulation in that same cycle.
module bin_accum_quant
  import readout_feature_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                bin_last_i,
  input  logic                clr_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [IN_BW-1:0]    code_o,
  output logic                bin_done_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, sum;

  assign sum        = acc_q + {{DEC_W{sample_i[SAMPLE_W-1]}}, sample_i};
  assign code_o     = quantize(sum);
  assign bin_done_o = en_i & bin_last_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i || bin_done_o) acc_d = '0;
    else if (en_i)           acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/readout_feature_quantizer.sv
// Window framing FSM, sample counter, shadow feature vector and the held output
// register feeding layer0 of the readout classifier.
module readout_feature_quantizer
  import readout_feature_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_i,
  input  logic [SAMPLE_W-1:0] s_q,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_W-1:0]    m_data,
  output logic                err_short,
  output logic                err_long
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   shadow_q, shadow_d, m_data_q;
  logic               m_valid_q, err_short_q, err_long_q;
  logic               accum_xfer, win_end, bin_last, short_clr;
  logic               done_i, done_q;
  logic [IN_BW-1:0]   code_i, code_q;
  logic [CNT_W-DEC_W-1:0] bin_idx;

  assign s_ready    = (state_q != HOLD);
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;

  assign accum_xfer = s_valid && (state_q == ACCUM);
  assign win_end    = (cnt_q == CNT_W'(W - 1));
  assign bin_last   = &cnt_q[DEC_W-1:0];
  assign bin_idx    = cnt_q[CNT_W-1:DEC_W];
  // A short window must not leak its partial bin into the next window.
  assign short_clr  = accum_xfer && s_last && !win_end;

  bin_accum_quant u_acc_i (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (accum_xfer),
    .bin_last_i (bin_last),
    .clr_i      (short_clr),
    .sample_i   (s_i),
    .code_o     (code_i),
    .bin_done_o (done_i)
  );

  bin_accum_quant u_acc_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (accum_xfer),
    .bin_last_i (bin_last),
    .clr_i      (short_clr),
    .sample_i   (s_q),
    .code_o     (code_q),
    .bin_done_o (done_q)
  );

  // The merged view lets the final bin reach m_data on the same edge it completes.
  always_comb begin
    shadow_d = shadow_q;
    if (done_i) shadow_d[int'(bin_idx) * IN_BW +: IN_BW] = code_i;
    if (done_q) shadow_d[(NUM_BINS + int'(bin_idx)) * IN_BW +: IN_BW] = code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      shadow_q    <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      shadow_q    <= shadow_d;
      case (state_q)
        ACCUM: begin
          if (s_valid) begin
            if (win_end) begin
              cnt_q <= '0;
              if (s_last) begin
                m_data_q  <= shadow_d;
                m_valid_q <= 1'b1;
                state_q   <= HOLD;
              end else begin
                err_long_q <= 1'b1;
                state_q    <= DRAIN;
              end
            end else if (s_last) begin
              cnt_q       <= '0;
              err_short_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (s_valid && s_last) state_q <= ACCUM;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_feature_quantizer.sv
// Directed bench for readout_feature_quantizer: full, saturating, short, long,
// back-pressured and reset-interrupted windows against hand-derived feature codes.
module tb_readout_feature_quantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_i = '0;
  logic [15:0] s_q = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        err_short;
  logic        err_long;

  int npass  = 0;
  int ntotal = 0;

  logic [63:0] exp1, exp2, exp5, exp6;

  readout_feature_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_i       (s_i),
    .s_q       (s_q),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_short (err_short),
    .err_long  (err_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // All I bins get ic except bin 3 (i3); all Q bins get qc.
  function automatic logic [63:0] vec(input logic [1:0] ic, input logic [1:0] qc,
                                      input logic [1:0] i3);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) begin
      v[b*2 +: 2]        = (b == 3) ? i3 : ic;
      v[(16 + b)*2 +: 2] = qc;
    end
    return v;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic send(input int iv, input int qv, input bit last);
    s_valid = 1'b1;
    s_i     = 16'(iv);
    s_q     = 16'(qv);
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic window(input int iv, input int qv, input int i3v, input bit gaps);
    for (int k = 0; k < 128; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(((k / 8) == 3) ? i3v : iv, qv, k == 127);
    end
  endtask

  initial begin
    exp1 = vec(2'b01, 2'b10, 2'b01);
    exp2 = vec(2'b01, 2'b00, 2'b10);
    exp5 = vec(2'b11, 2'b00, 2'b11);
    exp6 = vec(2'b00, 2'b11, 2'b00);

    repeat (2) @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_err_short", 64'(err_short), 64'd0);
    check("rst_err_long", 64'(err_long), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal window
    window(1000, -1000, 1000, 1'b0);
    check("t1_valid_latency", 64'(m_valid), 64'd1);
    check("t1_data", m_data, exp1);
    check("t1_ready_hold", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("t1_valid_drop", 64'(m_valid), 64'd0);
    check("t1_ready_back", 64'(s_ready), 64'd1);
    check("t1_data_persist", m_data, exp1);

    // Saturation both ways
    window(4000, 0, -4000, 1'b0);
    check("t2_valid", 64'(m_valid), 64'd1);
    check("t2_data", m_data, exp2);
    @(negedge clk);

    // Short window, then leftover-free full window
    for (int k = 0; k <= 50; k++) send(-3000, 3000, k == 50);
    check("t3_err_short", 64'(err_short), 64'd1);
    check("t3_no_valid", 64'(m_valid), 64'd0);
    check("t3_no_long", 64'(err_long), 64'd0);
    @(negedge clk);
    check("t3_err_short_pulse", 64'(err_short), 64'd0);
    window(1000, -1000, 1000, 1'b0);
    check("t3_next_data", m_data, exp1);
    check("t3_next_valid", 64'(m_valid), 64'd1);
    @(negedge clk);

    // Long window with drained tail
    for (int k = 0; k <= 129; k++) begin
      send(-4000, 4000, k == 129);
      if (k == 127) begin
        check("t4_err_long", 64'(err_long), 64'd1);
        check("t4_no_valid", 64'(m_valid), 64'd0);
      end
      if (k == 128) check("t4_err_long_pulse", 64'(err_long), 64'd0);
    end
    check("t4_drain_no_valid", 64'(m_valid), 64'd0);
    check("t4_drain_no_short", 64'(err_short), 64'd0);
    check("t4_ready", 64'(s_ready), 64'd1);
    window(1000, -1000, 1000, 1'b0);
    check("t4_next_data", m_data, exp1);
    @(negedge clk);

    // Back-pressure: offered samples must be refused while holding
    m_ready = 1'b0;
    window(-500, 500, -500, 1'b0);
    check("t5_valid", 64'(m_valid), 64'd1);
    check("t5_data", m_data, exp5);
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_i     = 16'h1234;
    repeat (20) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(m_valid), 64'd1);
      check("t5_hold_ready", 64'(s_ready), 64'd0);
      check("t5_hold_data", m_data, exp5);
      check("t5_hold_no_err", 64'({err_short, err_long}), 64'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t5_release_valid", 64'(m_valid), 64'd0);
    check("t5_release_ready", 64'(s_ready), 64'd1);
    check("t5_release_data", m_data, exp5);
    window(1000, -1000, 1000, 1'b1);
    check("t5_gap_valid", 64'(m_valid), 64'd1);
    check("t5_gap_data", m_data, exp1);
    @(negedge clk);

    // Reset mid-window (partial bin 5 pending)
    for (int k = 0; k <= 42; k++) send(1000, -1000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_data", m_data, 64'd0);
    check("t6_async_valid", 64'(m_valid), 64'd0);
    check("t6_async_ready", 64'(s_ready), 64'd1);
    check("t6_async_err", 64'({err_short, err_long}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_err", 64'({err_short, err_long}), 64'd0);
    window(500, -500, 500, 1'b0);
    check("t6_fresh_valid", 64'(m_valid), 64'd1);
    check("t6_fresh_data", m_data, exp6);
    @(negedge clk);

    // Reset while holding
    m_ready = 1'b0;
    window(1000, -1000, 1000, 1'b0);
    check("t7_hold_valid", 64'(m_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_valid", 64'(m_valid), 64'd0);
    check("t7_async_data", m_data, 64'd0);
    check("t7_async_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("t7_post_err", 64'({err_short, err_long}), 64'd0);
    window(500, -500, 500, 1'b0);
    check("t7_fresh_valid", 64'(m_valid), 64'd1);
    check("t7_fresh_data", m_data, exp6);
    @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
